// File: rtl/hmac_pkg.sv
// Shared constants and types for the HMAC-SHA1 sequencer.
// Pad patterns, word counts and the sequencer state encoding live here.
package hmac_pkg;

    localparam int KEY_WORDS    = 16;
    localparam int DIGEST_WORDS = 5;

    localparam logic [31:0] IPAD_PAT = 32'h36363636;
    localparam logic [31:0] OPAD_PAT = 32'h5c5c5c5c;

    localparam logic [3:0] LAST_KEY_WORD    = 4'(KEY_WORDS - 1);
    localparam logic [3:0] LAST_DIGEST_WORD = 4'(DIGEST_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IPAD,
        S_MSG,
        S_WAIT_I,
        S_OPAD,
        S_DIG,
        S_WAIT_O,
        S_DONE
    } state_t;

    // Word k of a 160-bit digest, k = 0 being H0 in the top bits.
    function automatic logic [31:0] digest_word(input logic [159:0] digest, input logic [3:0] k);
        logic [31:0] word;
        case (k)
            4'd0:    word = digest[159:128];
            4'd1:    word = digest[127:96];
            4'd2:    word = digest[95:64];
            4'd3:    word = digest[63:32];
            4'd4:    word = digest[31:0];
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/hmac_key_regs.sv
// 16 x 32 key register file: one synchronous write port, one combinational read port.
// Word 0 is the most significant key word.
module hmac_key_regs
    import hmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [KEY_WORDS];

    // NOTE: this storage must read back as zero after reset, so it is built from
    // resettable flops rather than a RAM macro; a plain RAM would keep stale key bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hmac_seq.sv
// HMAC-SHA1 sequencer: streams K^ipad, the message, K^opad and the inner digest
// to an external SHA-1 padding/compression stage and captures the final MAC.
module hmac_seq
    import hmac_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_we,
    input  logic [3:0]   key_addr,
    input  logic [31:0]  key_wdata,
    input  logic         go,
    input  logic         abort,
    input  logic [31:0]  m_tdata,
    input  logic         m_tvalid,
    input  logic         m_tlast,
    output logic         m_tready,
    output logic [31:0]  p_tdata,
    output logic         p_tvalid,
    output logic         p_tlast,
    input  logic         p_tready,
    input  logic         d_valid,
    input  logic [159:0] d_word,
    output logic [159:0] mac,
    output logic         mac_valid,
    output logic         busy
);

    state_t        state;
    logic [3:0]    cnt;
    logic [159:0]  inner;
    logic [31:0]   key_rdata;
    logic          xfer;
    logic          aborting;

    hmac_key_regs u_key_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (key_we && (state == S_IDLE)),
        .waddr (key_addr),
        .wdata (key_wdata),
        .raddr (cnt),
        .rdata (key_rdata)
    );

    assign busy     = (state != S_IDLE);
    assign aborting = abort && busy;

    // NOTE: every output gets a default at the top of the block so no path
    // leaves one unassigned; that is what keeps this logic free of latches.
    always_comb begin
        p_tdata  = '0;
        p_tvalid = 1'b0;
        p_tlast  = 1'b0;
        m_tready = 1'b0;
        case (state)
            S_IPAD: begin
                p_tdata  = key_rdata ^ IPAD_PAT;
                p_tvalid = 1'b1;
            end
            S_MSG: begin
                p_tdata  = m_tdata;
                p_tvalid = m_tvalid;
                p_tlast  = m_tlast;
                m_tready = p_tready;
            end
            S_OPAD: begin
                p_tdata  = key_rdata ^ OPAD_PAT;
                p_tvalid = 1'b1;
            end
            S_DIG: begin
                p_tdata  = digest_word(inner, cnt);
                p_tvalid = 1'b1;
                p_tlast  = (cnt == LAST_DIGEST_WORD);
            end
            default: ;
        endcase
        // An abort suppresses any handshake in the cycle it is raised.
        if (aborting) begin
            p_tvalid = 1'b0;
            m_tready = 1'b0;
        end
    end

    assign xfer = p_tvalid && p_tready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            inner     <= '0;
            mac       <= '0;
            mac_valid <= 1'b0;
        end else begin
            mac_valid <= 1'b0;
            if (aborting) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go) begin
                            cnt   <= '0;
                            state <= S_IPAD;
                        end
                    end
                    S_IPAD: begin
                        if (xfer) begin
                            cnt <= cnt + 4'd1;
                            if (cnt == LAST_KEY_WORD) state <= S_MSG;
                        end
                    end
                    S_MSG: begin
                        if (xfer && m_tlast) state <= S_WAIT_I;
                    end
                    S_WAIT_I: begin
                        if (d_valid) begin
                            inner <= d_word;
                            cnt   <= '0;
                            state <= S_OPAD;
                        end
                    end
                    S_OPAD: begin
                        if (xfer) begin
                            if (cnt == LAST_KEY_WORD) begin
                                cnt   <= '0;
                                state <= S_DIG;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    S_DIG: begin
                        if (xfer) begin
                            cnt <= cnt + 4'd1;
                            if (cnt == LAST_DIGEST_WORD) state <= S_WAIT_O;
                        end
                    end
                    S_WAIT_O: begin
                        if (d_valid) begin
                            mac       <= d_word;
                            mac_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
